// File: rtl/countdown_timer_ctrl.sv
// countdown_timer_ctrl
//   BCD MM:SS countdown timer sequenced by the 1 Hz divider square wave.
//   Start/stop/clear/load control, with an alarm held for ALARM_SECS seconds
//   after expiry.
//
// Ports
//   clk        in   system clock (100 MHz)
//   rst        in   asynchronous, active-high reset
//   sec_clk    in   divider square wave; each rising edge is one second
//   btn_start  in   start/resume pulse (one clk cycle)
//   btn_stop   in   pause pulse
//   btn_clear  in   clear pulse
//   load_en    in   load preset pulse
//   load_bcd   in   preset {min_tens, min_ones, sec_tens, sec_ones}
//   digits     out  current time, same packing as load_bcd
//   state      out  0=IDLE 1=RUN 2=PAUSE 3=DONE
//   alarm      out  high during the alarm window
//   done_pulse out  one-cycle pulse on entry to DONE
module countdown_timer_ctrl #(
  parameter int unsigned ALARM_SECS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sec_clk,
  input  logic        btn_start,
  input  logic        btn_stop,
  input  logic        btn_clear,
  input  logic        load_en,
  input  logic [15:0] load_bcd,
  output logic [15:0] digits,
  output logic [1:0]  state,
  output logic        alarm,
  output logic        done_pulse
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [3:0] ALARM_INIT = 4'(ALARM_SECS);

  logic        r_sec_d;
  logic [15:0] r_digits;
  logic [1:0]  r_state;
  logic        r_alarm;
  logic [3:0]  r_alarm_cnt;
  logic        r_done_pulse;

  logic        w_tick;
  logic [15:0] w_dec;
  logic        w_dec_zero;
  logic        w_load_ok;
  logic        w_cmd_load;
  logic        w_cmd_stop;
  logic        w_cmd_start;
  logic [3:0]  w_cnt_dec;

  logic [15:0] w_nxt_digits;
  logic [1:0]  w_nxt_state;
  logic        w_nxt_alarm;
  logic [3:0]  w_nxt_alarm_cnt;
  logic        w_nxt_done_pulse;

  assign w_tick    = sec_clk & ~r_sec_d;
  assign w_cnt_dec = r_alarm_cnt - 4'd1;

  assign w_load_ok = (load_bcd[3:0]   <= 4'd9) && (load_bcd[7:4]   <= 4'd5) &&
                     (load_bcd[11:8]  <= 4'd9) && (load_bcd[15:12] <= 4'd9);

  // An invalid preset is not an applicable command, so it does not mask
  // stop/start/tick in the same cycle.
  assign w_cmd_load  = load_en && (r_state != ST_RUN) && w_load_ok;
  assign w_cmd_stop  = btn_stop && (r_state == ST_RUN);
  assign w_cmd_start = btn_start &&
                       (((r_state == ST_IDLE) && (r_digits != '0)) ||
                        (r_state == ST_PAUSE));

  // BCD borrow chain: sec_ones -> sec_tens (mod 6) -> min_ones -> min_tens.
  // RUN never holds 00:00, so min_tens is non-zero whenever it is reached.
  always_comb begin
    w_dec = r_digits;
    if (r_digits[3:0] != 4'd0) begin
      w_dec[3:0] = r_digits[3:0] - 4'd1;
    end else begin
      w_dec[3:0] = 4'd9;
      if (r_digits[7:4] != 4'd0) begin
        w_dec[7:4] = r_digits[7:4] - 4'd1;
      end else begin
        w_dec[7:4] = 4'd5;
        if (r_digits[11:8] != 4'd0) begin
          w_dec[11:8] = r_digits[11:8] - 4'd1;
        end else begin
          w_dec[11:8]  = 4'd9;
          w_dec[15:12] = r_digits[15:12] - 4'd1;
        end
      end
    end
  end

  assign w_dec_zero = (w_dec == '0);

  always_comb begin
    w_nxt_digits     = r_digits;
    w_nxt_state      = r_state;
    w_nxt_alarm      = r_alarm;
    w_nxt_alarm_cnt  = r_alarm_cnt;
    w_nxt_done_pulse = 1'b0;

    if (btn_clear) begin
      w_nxt_state     = ST_IDLE;
      w_nxt_digits    = '0;
      w_nxt_alarm     = 1'b0;
      w_nxt_alarm_cnt = '0;
    end else if (w_cmd_load) begin
      w_nxt_state     = ST_IDLE;
      w_nxt_digits    = load_bcd;
      w_nxt_alarm     = 1'b0;
      w_nxt_alarm_cnt = '0;
    end else if (w_cmd_stop) begin
      w_nxt_state = ST_PAUSE;
    end else if (w_cmd_start) begin
      w_nxt_state = ST_RUN;
    end else if (w_tick) begin
      if (r_state == ST_RUN) begin
        w_nxt_digits = w_dec;
        if (w_dec_zero) begin
          w_nxt_state      = ST_DONE;
          w_nxt_alarm      = 1'b1;
          w_nxt_alarm_cnt  = ALARM_INIT;
          w_nxt_done_pulse = 1'b1;
        end
      end else if ((r_state == ST_DONE) && r_alarm) begin
        w_nxt_alarm_cnt = w_cnt_dec;
        if (w_cnt_dec == 4'd0) begin
          w_nxt_alarm = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sec_d      <= 1'b0;
      r_digits     <= '0;
      r_state      <= ST_IDLE;
      r_alarm      <= 1'b0;
      r_alarm_cnt  <= '0;
      r_done_pulse <= 1'b0;
    end else begin
      r_sec_d      <= sec_clk;
      r_digits     <= w_nxt_digits;
      r_state      <= w_nxt_state;
      r_alarm      <= w_nxt_alarm;
      r_alarm_cnt  <= w_nxt_alarm_cnt;
      r_done_pulse <= w_nxt_done_pulse;
    end
  end

  assign digits     = r_digits;
  assign state      = r_state;
  assign alarm      = r_alarm;
  assign done_pulse = r_done_pulse;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb_countdown_timer_ctrl
//   Directed stimulus for countdown_timer_ctrl. Each driven cycle pushes the
//   hand-computed output expected after the next clk edge into a queue; a
//   monitor on the falling edge pops and compares entries when they fall due.
module tb_countdown_timer_ctrl;

  localparam logic [1:0] I = 2'd0;
  localparam logic [1:0] R = 2'd1;
  localparam logic [1:0] P = 2'd2;
  localparam logic [1:0] D = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sec_clk = 1'b0;
  logic        btn_start = 1'b0;
  logic        btn_stop = 1'b0;
  logic        btn_clear = 1'b0;
  logic        load_en = 1'b0;
  logic [15:0] load_bcd = '0;
  logic [15:0] digits;
  logic [1:0]  state;
  logic        alarm;
  logic        done_pulse;

  countdown_timer_ctrl #(.ALARM_SECS(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .sec_clk    (sec_clk),
    .btn_start  (btn_start),
    .btn_stop   (btn_stop),
    .btn_clear  (btn_clear),
    .load_en    (load_en),
    .load_bcd   (load_bcd),
    .digits     (digits),
    .state      (state),
    .alarm      (alarm),
    .done_pulse (done_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [15:0] d;
    logic [1:0]  s;
    logic        a;
    logic        p;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [15:0] ed, input logic [1:0] es,
                         input logic ea, input logic ep);
    chk({nm, ".digits"}, 32'(digits), 32'(ed));
    chk({nm, ".state"}, 32'(state), 32'(es));
    chk({nm, ".alarm"}, 32'(alarm), 32'(ea));
    chk({nm, ".done_pulse"}, 32'(done_pulse), 32'(ep));
  endtask

  // Monitor: compares every queued expectation on the falling edge of its cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.due != cyc) chk({e.nm, ".late"}, 32'(cyc), 32'(e.due));
      chk_all(e.nm, e.d, e.s, e.a, e.p);
    end
  end

  // Drive one cycle of inputs (called at posedge+1) and queue the outputs
  // expected after the coming edge.
  task automatic drv(input logic st, input logic sp, input logic cl, input logic ld,
                     input logic [15:0] bcd, input logic sc,
                     input logic [15:0] ed, input logic [1:0] es,
                     input logic ea, input logic ep, input string nm);
    exp_t e;
    btn_start = st;
    btn_stop  = sp;
    btn_clear = cl;
    load_en   = ld;
    load_bcd  = bcd;
    sec_clk   = sc;
    e.due = cyc + 1;
    e.d = ed; e.s = es; e.a = ea; e.p = ep; e.nm = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [15:0] ed, input logic [1:0] es, input logic ea, input string nm);
    drv(0, 0, 0, 0, '0, 0, ed, es, ea, 0, nm);
  endtask

  // One sec_clk rising edge (high one cycle, then low one cycle).
  task automatic tk(input logic [15:0] ed, input logic [1:0] es, input logic ea,
                    input logic ep, input string nm);
    drv(0, 0, 0, 0, '0, 1, ed, es, ea, ep, nm);
    idle(ed, es, ea, {nm, "_low"});
  endtask

  task automatic load(input logic [15:0] bcd, input logic [15:0] ed, input logic [1:0] es,
                      input string nm);
    drv(0, 0, 0, 1, bcd, 0, ed, es, 0, 0, nm);
  endtask

  task automatic start(input logic [15:0] ed, input logic [1:0] es, input string nm);
    drv(1, 0, 0, 0, '0, 0, ed, es, 0, 0, nm);
  endtask

  task automatic stop(input logic [15:0] ed, input logic [1:0] es, input string nm);
    drv(0, 1, 0, 0, '0, 0, ed, es, 0, 0, nm);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 16'h0000, I, 0, 0);
    rst = 1'b0;

    // 00:03 countdown to expiry and the alarm window
    load(16'h0003, 16'h0003, I, "ld3");
    start(16'h0003, R, "st3");
    tk(16'h0002, R, 0, 0, "t3_1");
    tk(16'h0001, R, 0, 0, "t3_2");
    tk(16'h0000, D, 1, 1, "t3_3");
    for (int i = 1; i <= 9; i++) tk(16'h0000, D, 1, 0, "alarm_hi");
    tk(16'h0000, D, 0, 0, "alarm_off");
    tk(16'h0000, D, 0, 0, "alarm_stays_off");

    // Borrow across minutes, load from DONE
    load(16'h1000, 16'h1000, I, "ld1000");
    start(16'h1000, R, "st1000");
    tk(16'h0959, R, 0, 0, "borrow_959");
    tk(16'h0958, R, 0, 0, "t958");

    // Pause / resume
    stop(16'h0958, P, "stop958");
    load(16'h0105, 16'h0105, I, "ld105");
    start(16'h0105, R, "st105");
    tk(16'h0104, R, 0, 0, "t104");
    tk(16'h0103, R, 0, 0, "t103");
    stop(16'h0103, P, "stop103");
    for (int i = 0; i < 5; i++) tk(16'h0103, P, 0, 0, "pause_tick");
    start(16'h0103, R, "resume");
    tk(16'h0102, R, 0, 0, "t102");

    // Stop and tick in the same cycle at 00:30
    stop(16'h0102, P, "stop102");
    load(16'h0030, 16'h0030, I, "ld30");
    start(16'h0030, R, "st30");
    drv(0, 1, 0, 0, '0, 1, 16'h0030, P, 0, 0, "stop_tick");
    idle(16'h0030, P, 0, "stop_tick_low");
    tk(16'h0030, P, 0, 0, "pause_after");

    // Invalid load, load during RUN, start with zero
    drv(0, 0, 1, 0, '0, 0, 16'h0000, I, 0, 0, "clr");
    load(16'h0030, 16'h0030, I, "ld30b");
    load(16'h0070, 16'h0030, I, "ld_invalid");
    start(16'h0030, R, "st30b");
    load(16'h0010, 16'h0030, R, "ld_in_run");
    drv(0, 0, 1, 0, '0, 0, 16'h0000, I, 0, 0, "clr2");
    start(16'h0000, I, "start_zero");

    // 99:59 and simultaneous start+stop
    load(16'h9959, 16'h9959, I, "ld9959");
    start(16'h9959, R, "st9959");
    tk(16'h9958, R, 0, 0, "t9958");
    drv(1, 1, 0, 0, '0, 0, 16'h9958, P, 0, 0, "ss_run");
    drv(1, 1, 0, 0, '0, 0, 16'h9958, R, 0, 0, "ss_pause");

    // Clear + load during DONE with alarm high
    drv(0, 0, 1, 0, '0, 0, 16'h0000, I, 0, 0, "clr3");
    load(16'h0001, 16'h0001, I, "ld1");
    start(16'h0001, R, "st1");
    tk(16'h0000, D, 1, 1, "t1_exp");
    drv(0, 0, 1, 1, 16'h0005, 0, 16'h0000, I, 0, 0, "clr_ld_done");

    // Asynchronous reset mid-RUN
    load(16'h0500, 16'h0500, I, "ld500");
    start(16'h0500, R, "st500");
    tk(16'h0459, R, 0, 0, "t459");
    @(negedge clk);
    #2;
    chk_all("pre_rst", 16'h0459, R, 0, 0);
    rst = 1'b1;
    #1;
    chk_all("async_rst", 16'h0000, I, 0, 0);
    @(posedge clk);
    #1;
    chk_all("rst_held", 16'h0000, I, 0, 0);
    rst = 1'b0;

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/countdown_timer_ctrl.md
Name: countdown_timer_ctrl

Overview:
- Sequences the 1 Hz divider output into a BCD MM:SS countdown timer with start/stop/clear/load control and a timed alarm.
- Sits between the 100 MHz clock divider (square wave in, 1 s period) and the 7-segment display/alarm drivers.
- Button inputs arrive already debounced as single-cycle pulses in the clk domain.

Parameters:
- ALARM_SECS, 10, number of sec_clk rising edges for which alarm stays high after expiry (1..15).

Ports:
- clk  in  1  100 MHz system clock.
- rst  in  1  asynchronous, active-high reset.
- sec_clk  in  1  divider square wave, same clock domain; each rising edge is one second.
- btn_start  in  1  start/resume pulse.
- btn_stop  in  1  pause pulse.
- btn_clear  in  1  clear pulse.
- load_en  in  1  load preset pulse.
- load_bcd  in  16  preset {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each.
- digits  out  16  current time, same packing as load_bcd.
- state  out  2  0=IDLE, 1=RUN, 2=PAUSE, 3=DONE.
- alarm  out  1  high during alarm window.
- done_pulse  out  1  one-cycle pulse on entry to DONE.

Behaviour:
- Reset (async) values: digits=0x0000, state=IDLE, alarm=0, done_pulse=0, sec_d=0, alarm_cnt=0.
- Edge detect: sec_d registers sec_clk. tick = sec_clk & ~sec_d (combinational).
  - If sec_clk is high at reset release, one tick is produced. It is harmless in IDLE.
- All state, digit and alarm updates are registered on the clk edge ending the cycle in which the condition holds. Latency is 1 clk from tick or button to output.
- Command priority per cycle: btn_clear > load_en > btn_stop > btn_start > tick.
  - Only the highest-priority applicable command acts.
  - Tick is consumed only when no command acts in that cycle.
- btn_clear, any state: state=IDLE, digits=0x0000, alarm=0, alarm_cnt=0.
- load_en in IDLE, PAUSE or DONE:
  - Load is valid when sec_ones≤9, sec_tens≤5, min_ones≤9 and min_tens≤9.
  - Valid: digits=load_bcd, state=IDLE, alarm=0.
  - Invalid: load ignored entirely (no state or digit change).
  - load_en in RUN is ignored.
- btn_start:
  - IDLE with digits≠0 → RUN.
  - IDLE with digits=0 → stay IDLE.
  - PAUSE → RUN.
  - RUN or DONE: ignored.
- btn_stop: RUN → PAUSE; ignored elsewhere.
  - Simultaneous start+stop: in RUN stop wins (→PAUSE); in PAUSE stop is inapplicable, start wins (→RUN).
- Tick in RUN decrements BCD MM:SS with borrow chain:
  - sec_ones 0→9 borrows from sec_tens.
  - sec_tens 0→5 borrows from min_ones.
  - min_ones 0→9 borrows from min_tens.
- Expiry: if the decrement result is 00:00, on the same edge: state=DONE, alarm=1, alarm_cnt=ALARM_SECS, done_pulse=1 for exactly that one cycle.
- Tick in DONE with alarm=1: alarm_cnt decrements; when it reaches 0, alarm=0 on that edge. Alarm is therefore high for exactly ALARM_SECS ticks.
- Tick in IDLE or PAUSE: no effect.
- Digits never wrap below 00:00. RUN is never entered with 00:00.
- Maximum time is 99:59. 99:59 decrements to 99:58.
- Reset asserted mid-RUN or mid-alarm: immediate return to reset values; no done_pulse.

Test Plan:
- Reset, load 0x0003, start, 3 sec_clk rising edges → digits 0x0002, 0x0001, 0x0000; state=DONE and done_pulse=1 one cycle after the 3rd edge; alarm high for 10 further ticks, then 0.
- Load 0x1000 (10:00), start, 1 tick → digits 0x0959; 2nd tick → 0x0958.
- Load 0x0105, run 2 ticks, stop → PAUSE at 0x0103; 5 ticks → digits unchanged; start, 1 tick → 0x0102.
- Stop and tick in the same cycle while RUN at 0x0030 → PAUSE, digits remain 0x0030.
- Load 0x0070 (sec_tens=7) in IDLE → ignored, digits unchanged. Load 0x0010 during RUN → ignored. Start with 0x0000 in IDLE → remains IDLE.
- Clear and load asserted together during DONE with alarm high → IDLE, digits 0x0000, alarm 0. Async rst mid-RUN → all outputs zero without waiting for a clk edge.
